sha2_round_engine: RTL and testbench

SHA2_ROUND_ENGINE -- requirements
Module: sha2_round_engine

---
 rtl/sha2_pkg.sv | 32 +++
 rtl/sha2_round_engine.sv | 159 +++++++++++++++
 tb/tb_sha2_round_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 round constants. The SHA-256 table is the upper 32 bits of the
// first 64 SHA-512 constants, so k256() reads the 64-bit table.
package sha2_pkg;

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [31:0] k256(logic [5:0] t);
        return K512[t][63:32];
    endfunction

endpackage

// File: rtl/sha2_round_engine.sv
// SHA-256/SHA-512 compression engine, UNROLL rounds per clock.
// Optional abort input enabled by defining SHA2_ABORT_EN.
module sha2_round_engine #(
    parameter int WORD_W = 32,
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORD_W-1:0]  block_in,
    input  logic [8*WORD_W-1:0]   hash_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*WORD_W-1:0]   hash_out,
`ifdef SHA2_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy
);
    import sha2_pkg::*;

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_round_engine: WORD_W must be 32 or 64");
        end
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $error("sha2_round_engine: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam bit         W64        = (WORD_W == 64);
    localparam int         NUM_ROUNDS = W64 ? 80 : 64;
    localparam logic [6:0] ROUNDS_C   = 7'(NUM_ROUNDS);
    localparam logic [6:0] STEP       = 7'(UNROLL);

    // FIPS 180-4 rotate/shift amounts
    localparam int BS0A = W64 ? 28 : 2,  BS0B = W64 ? 34 : 13, BS0C = W64 ? 39 : 22;
    localparam int BS1A = W64 ? 14 : 6,  BS1B = W64 ? 18 : 11, BS1C = W64 ? 41 : 25;
    localparam int SS0A = W64 ? 1  : 7,  SS0B = W64 ? 8  : 18, SS0C = W64 ? 7  : 3;
    localparam int SS1A = W64 ? 19 : 17, SS1B = W64 ? 61 : 19, SS1C = W64 ? 6  : 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [7:0][WORD_W-1:0] state_t;   // index 0 = a ... 7 = h

    function automatic word_t rotr(word_t x, int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t bsig0(word_t x);
        return rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
    endfunction

    function automatic word_t bsig1(word_t x);
        return rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
    endfunction

    function automatic word_t ssig0(word_t x);
        return rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
    endfunction

    function automatic word_t ssig1(word_t x);
        return rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
    endfunction

    function automatic word_t kconst(logic [6:0] t);
        logic [6:0] idx;
        idx = (t < ROUNDS_C) ? t : 7'd0;
        if (W64) return word_t'(K512[idx]);
        return word_t'(k256(idx[5:0]));
    endfunction

    function automatic state_t round_f(state_t s, word_t k, word_t w);
        word_t  t1, t2;
        state_t n;
        t1   = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2   = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        n[7] = s[6];
        n[6] = s[5];
        n[5] = s[4];
        n[4] = s[3] + t1;
        n[3] = s[2];
        n[2] = s[1];
        n[1] = s[0];
        n[0] = t1 + t2;
        return n;
    endfunction

    logic [1:0]               state;
    logic [6:0]               cnt;
    state_t                   wk, hsave;
    logic [15:0][WORD_W-1:0]  win;      // win[0] is W[t] for the current round
    logic [15+UNROLL:0][WORD_W-1:0] ext;
    state_t                   st [0:UNROLL];

    // Schedule extension and round chain for this cycle's UNROLL rounds.
    always_comb begin
        ext        = '0;
        ext[15:0]  = win;
        for (int u = 0; u < UNROLL; u++)
            ext[16+u] = ssig1(ext[14+u]) + ext[9+u] + ssig0(ext[1+u]) + ext[u];
        st[0] = wk;
        for (int u = 0; u < UNROLL; u++)
            st[u+1] = round_f(st[u], kconst(cnt + 7'(u)), ext[u]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wk       <= '0;
            hsave    <= '0;
            win      <= '0;
            hash_out <= '0;
        end
`ifdef SHA2_ABORT_EN
        else if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hash_out <= '0;
        end
`endif
        else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    state <= S_ROUND;
                    cnt   <= '0;
                    for (int i = 0; i < 16; i++)
                        win[i] <= block_in[(15-i)*WORD_W +: WORD_W];
                    for (int i = 0; i < 8; i++) begin
                        wk[i]    <= hash_in[(7-i)*WORD_W +: WORD_W];
                        hsave[i] <= hash_in[(7-i)*WORD_W +: WORD_W];
                    end
                end
                // Final cycle of ROUND folds the working state into H.
                S_ROUND: if (cnt == ROUNDS_C) begin
                    state <= S_DONE;
                    for (int i = 0; i < 8; i++)
                        hash_out[(7-i)*WORD_W +: WORD_W] <= hsave[i] + wk[i];
                end else begin
                    wk  <= st[UNROLL];
                    win <= ext[15+UNROLL:UNROLL];
                    cnt <= cnt + STEP;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ROUND) || (state == S_DONE);

endmodule

// File: tb/tb_sha2_round_engine.sv
// Bench for sha2_round_engine: three configurations (32/1, 32/2, 64/4) checked
// against known digests and a software SHA-2 compression model.
module tb_sha2_round_engine;
    import sha2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           iv   [3];
    logic           ordy [3];
    logic           ab   [3];
    logic [1023:0]  blk  [3];
    logic [511:0]   hin  [3];
    logic           ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [255:0]   ho0, ho1;
    logic [511:0]   ho2;

    int n_chk = 0;
    int n_err = 0;

    sha2_round_engine #(.WORD_W(32), .UNROLL(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .block_in(blk[0][511:0]), .hash_in(hin[0][255:0]), .out_valid(ov0),
        .out_ready(ordy[0]), .hash_out(ho0),
`ifdef SHA2_ABORT_EN
        .abort(ab[0]),
`endif
        .busy(bz0));

    sha2_round_engine #(.WORD_W(32), .UNROLL(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .block_in(blk[1][511:0]), .hash_in(hin[1][255:0]), .out_valid(ov1),
        .out_ready(ordy[1]), .hash_out(ho1),
`ifdef SHA2_ABORT_EN
        .abort(ab[1]),
`endif
        .busy(bz1));

    sha2_round_engine #(.WORD_W(64), .UNROLL(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .block_in(blk[2]), .hash_in(hin[2]), .out_valid(ov2),
        .out_ready(ordy[2]), .hash_out(ho2),
`ifdef SHA2_ABORT_EN
        .abort(ab[2]),
`endif
        .busy(bz2));

    localparam logic [1023:0] ABC256 = {512'h0, 32'h61626380, 448'h0, 32'h18};
    localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};
    localparam logic [1023:0] TWO_A  = {512'h0,
        256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
        192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 64'h8000000000000000};
    localparam logic [1023:0] TWO_B  = {512'h0, 480'h0, 32'h000001c0};
    localparam logic [511:0]  IV256  = {256'h0,
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19};
    localparam logic [511:0]  IV512  =
        512'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179;
    localparam logic [511:0]  D_ABC256 = {256'h0,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
    localparam logic [511:0]  D_TWO    = {256'h0,
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
    localparam logic [511:0]  D_ABC512 = {64'hddaf35a193617aba, 416'h0, 32'ha54ca49f};
    localparam logic [511:0]  M256     = {256'h0, {256{1'b1}}};
    localparam logic [511:0]  M512BE   = {64'hffffffffffffffff, 416'h0, 32'hffffffff};

    typedef struct {
        string          name;
        int             d;
        logic [1023:0]  blk;
        logic [511:0]   hv;
        bit             chain;   // take hash_in from the previous vector's digest
        logic [511:0]   kat;
        logic [511:0]   kmask;
    } vec_t;
    vec_t tbl [4];

    function automatic logic get_ir(int d);
        case (d) 0: return ir0; 1: return ir1; default: return ir2; endcase
    endfunction
    function automatic logic get_ov(int d);
        case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction
    function automatic logic get_bz(int d);
        case (d) 0: return bz0; 1: return bz1; default: return bz2; endcase
    endfunction
    function automatic logic [511:0] get_ho(int d);
        case (d) 0: return 512'(ho0); 1: return 512'(ho1); default: return ho2; endcase
    endfunction
    function automatic int exp_lat(int d);
        case (d) 0: return 65; 1: return 33; default: return 21; endcase
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model: plain FIPS 180-4 compression ----------------
    function automatic longint unsigned rr(longint unsigned x, int n, bit w64);
        if (w64) return (x >> n) | (x << (64 - n));
        return ((x >> n) | (x << (32 - n))) & 64'hffffffff;
    endfunction

    function automatic logic [511:0] ref_compress(bit w64, logic [1023:0] b, logic [511:0] hv);
        longint unsigned m, t1, t2, s0, s1, ch, mj, kk;
        longint unsigned w [80];
        longint unsigned h [8];
        longint unsigned v [8];
        logic [511:0]    r;
        int              nr;
        m  = w64 ? 64'hffffffffffffffff : 64'hffffffff;
        nr = w64 ? 80 : 64;
        for (int i = 0; i < 16; i++)
            w[i] = w64 ? b[1023-64*i -: 64] : 64'(b[511-32*i -: 32]);
        for (int i = 0; i < 8; i++) begin
            h[i] = w64 ? hv[511-64*i -: 64] : 64'(hv[255-32*i -: 32]);
            v[i] = h[i];
        end
        for (int t = 16; t < nr; t++) begin
            if (w64) begin
                s0 = rr(w[t-15], 1, 1) ^ rr(w[t-15], 8, 1) ^ (w[t-15] >> 7);
                s1 = rr(w[t-2], 19, 1) ^ rr(w[t-2], 61, 1) ^ (w[t-2] >> 6);
            end else begin
                s0 = rr(w[t-15], 7, 0) ^ rr(w[t-15], 18, 0) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17, 0) ^ rr(w[t-2], 19, 0) ^ (w[t-2] >> 10);
            end
            w[t] = (s1 + w[t-7] + s0 + w[t-16]) & m;
        end
        for (int t = 0; t < nr; t++) begin
            if (w64) begin
                s1 = rr(v[4], 14, 1) ^ rr(v[4], 18, 1) ^ rr(v[4], 41, 1);
                s0 = rr(v[0], 28, 1) ^ rr(v[0], 34, 1) ^ rr(v[0], 39, 1);
                kk = K512[t];
            end else begin
                s1 = rr(v[4], 6, 0) ^ rr(v[4], 11, 0) ^ rr(v[4], 25, 0);
                s0 = rr(v[0], 2, 0) ^ rr(v[0], 13, 0) ^ rr(v[0], 22, 0);
                kk = K512[t] >> 32;
            end
            ch = (v[4] & v[5]) ^ (~v[4] & v[6] & m);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1 = (v[7] + s1 + ch + kk + w[t]) & m;
            t2 = (s0 + mj) & m;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
            v[4] = (v[3] + t1) & m;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
            v[0] = (t1 + t2) & m;
        end
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (w64) r[511-64*i -: 64] = h[i] + v[i];
            else     r[255-32*i -: 32] = 32'((h[i] + v[i]) & m);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present a block, wait for acceptance, then count edges until out_valid.
    task automatic run_block(input int d, input logic [1023:0] b, input logic [511:0] h,
                             output logic [511:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        iv[d] = 1'b1; blk[d] = b; hin[d] = h;
        while (!get_ir(d) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        iv[d] = 1'b0; blk[d] = rnd1024(); hin[d] = rnd1024()[511:0];
        check($sformatf("accept_busy_d%0d", d), 512'({get_bz(d), get_ir(d)}), 512'(2'b10));
        lat = 0;
        while (!get_ov(d) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_ho(d);
    endtask

    initial begin
        logic [511:0] res, prev, hv;
        logic [1023:0] b;
        int lat, ok;

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; ab[d] = 1'b0; blk[d] = '0; hin[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_d%0d", d),
                  512'({get_ir(d), get_ov(d), get_bz(d)}) ^ get_ho(d), 512'(3'b100));
        @(negedge clk) rst_n = 1'b1;

        tbl[0] = '{"abc256", 0, ABC256, IV256, 1'b0, D_ABC256, M256};
        tbl[1] = '{"abc512", 2, ABC512, IV512, 1'b0, D_ABC512, M512BE};
        tbl[2] = '{"two_blk1", 1, TWO_A, IV256, 1'b0, '0, '0};
        tbl[3] = '{"two_blk2", 1, TWO_B, IV256, 1'b1, D_TWO, M256};

        prev = '0;
        for (int i = 0; i < 4; i++) begin
            hv = tbl[i].chain ? prev : tbl[i].hv;
            run_block(tbl[i].d, tbl[i].blk, hv, res, lat);
            check({tbl[i].name, "_lat"}, 512'(lat), 512'(exp_lat(tbl[i].d)));
            check({tbl[i].name, "_model"}, res, ref_compress(tbl[i].d == 2, tbl[i].blk, hv));
            if (tbl[i].kmask != '0)
                check({tbl[i].name, "_kat"}, res & tbl[i].kmask, tbl[i].kat);
            prev = res;
        end

        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 3; d++) begin
                b  = rnd1024();
                hv = rnd1024()[511:0];
                run_block(d, b, hv, res, lat);
                check($sformatf("rand%0d_d%0d_lat", r, d), 512'(lat), 512'(exp_lat(d)));
                check($sformatf("rand%0d_d%0d_model", r, d), res,
                      ref_compress(d == 2, b, d == 2 ? hv : (hv & M256)));
            end
        end

        // Back-pressure in DONE: output held, extra in_valid ignored.
        ordy[0] = 1'b0;
        run_block(0, ABC256, IV256, res, lat);
        check("stall_digest", res, D_ABC256);
        ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv[0] = 1'b1; blk[0] = rnd1024();
            @(posedge clk); #1;
            if (!(ov0 && !ir0 && bz0 && 512'(ho0) == res)) ok = 0;
        end
        check("stall_hold", 512'(ok), 512'd1);
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("stall_release", 512'({ir0, ov0, bz0}), 512'(3'b100));
        @(posedge clk); #1;
        check("stall_no_restart", 512'({ir0, bz0}), 512'(2'b10));

        // Reset in the middle of ROUND discards the block.
        @(negedge clk);
        iv[0] = 1'b1; blk[0] = ABC256; hin[0] = IV256;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midreset_state", 512'({ov0, ir0, bz0, ho0}), 512'({1'b0, 1'b1, 1'b0, 256'h0}));
        @(negedge clk) rst_n = 1'b1;
        ok = 1;
        repeat (70) begin
            @(posedge clk); #1;
            if (ov0 || bz0) ok = 0;
        end
        check("midreset_no_output", 512'(ok), 512'd1);
        run_block(0, ABC256, IV256, res, lat);
        check("after_reset_digest", res, D_ABC256);
        check("after_reset_lat", 512'(lat), 512'd65);

`ifdef SHA2_ABORT_EN
        @(negedge clk);
        iv[0] = 1'b1; blk[0] = ABC256; hin[0] = IV256;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) ab[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_state", 512'({ov0, ir0, bz0, ho0}), 512'({1'b0, 1'b1, 1'b0, 256'h0}));
        ab[0] = 1'b0;
        ok = 1;
        repeat (80) begin
            @(posedge clk); #1;
            if (ov0 || bz0) ok = 0;
        end
        check("abort_no_output", 512'(ok), 512'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
